// File: rtl/cp0_pkg.sv
// Shared constants and types for the CP0 interrupt/trap block: register
// indices, exception codes, Status/Cause bit positions and the event kind.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXCCODE_INT = 5'd0;
  localparam logic [4:0] EXCCODE_SYS = 5'd8;
  localparam logic [4:0] EXCCODE_BRK = 5'd9;
  localparam logic [4:0] EXCCODE_TEQ = 5'd13;

  localparam int ST_IE     = 0;
  localparam int ST_SYS_EN = 1;
  localparam int ST_BRK_EN = 2;
  localparam int ST_TEQ_EN = 3;
  localparam int ST_IM_LSB = 8;
  localparam int ST_IM_MSB = 15;

  localparam int CA_EXC_LSB = 2;
  localparam int CA_EXC_MSB = 6;
  localparam int CA_IP_LSB  = 8;
  localparam int CA_IP_MSB  = 15;

  localparam int IP_HW_LSB = 2;
  localparam int IP_TIMER  = 7;

  // Only IE, the three trap enables and IM are implemented in Status.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF0F;

  typedef enum logic [2:0] {
    EXC_NONE,
    EXC_ERET,
    EXC_SYSCALL,
    EXC_BREAK,
    EXC_TEQ,
    EXC_INT
  } exc_kind_e;

  function automatic logic [4:0] exc_code(input exc_kind_e kind);
    logic [4:0] code;
    code = EXCCODE_INT;
    case (kind)
      EXC_SYSCALL: code = EXCCODE_SYS;
      EXC_BREAK:   code = EXCCODE_BRK;
      EXC_TEQ:     code = EXCCODE_TEQ;
      default:     code = EXCCODE_INT;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cp0_irq_if.sv
// Execute-stage <-> CP0 signal bundle. The core drives master, CP0 is the slave.
interface cp0_irq_if #(
  parameter int NUM_IRQ = 5
);
  logic               mfc0;
  logic               mtc0;
  logic [4:0]         rd;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               syscall;
  logic               breakc;
  logic               teq;
  logic               zero;
  logic               eret;
  logic [31:0]        pc;
  logic [NUM_IRQ-1:0] irq;
  logic [31:0]        status;
  logic               redirect;
  logic [31:0]        cp0_addr;
  logic               nest_full;

  modport master (
    output mfc0, mtc0, rd, wdata, syscall, breakc, teq, zero, eret, pc, irq,
    input  rdata, status, redirect, cp0_addr, nest_full
  );

  modport slave (
    input  mfc0, mtc0, rd, wdata, syscall, breakc, teq, zero, eret, pc, irq,
    output rdata, status, redirect, cp0_addr, nest_full
  );
endinterface

// File: rtl/cp0_status_stack.sv
// LIFO of saved Status words so trap handlers can nest; push on entry, pop on eret.
module cp0_status_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_data_i,
  output logic [31:0] top_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int W = $clog2(DEPTH + 1);

  logic [W-1:0] depth_q, depth_d;
  logic [31:0]  mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;

  always_comb begin
    depth_d = depth_q;
    if (do_push) depth_d = depth_q + W'(1);
    else if (do_pop) depth_d = depth_q - W'(1);
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!empty_o && (W'(i) == depth_q - W'(1))) top_o = mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      depth_q <= depth_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (depth_q == W'(i))) mem_q[i] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/cp0_irq.sv
// Coprocessor 0: traps, sampled interrupts, Count/Compare timer and nested
// Status save; produces mfc0 data and a same-cycle PC redirect.
module cp0_irq
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ    = 5,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter int          TIMER_EN   = 1
) (
  input logic     clk,
  input logic     rst,
  cp0_irq_if.slave bus
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [7:0]  ip_q, ip_d;

  logic        stk_empty, stk_full;
  logic [31:0] stk_top;

  exc_kind_e   kind;
  logic        ie;
  logic [7:0]  im;
  logic        take_eret, take_exc, redirect;
  logic        wr_en;
  logic [31:0] target;
  logic [31:0] cause_w;
  logic [31:0] rdata_w;

  assign ie = status_q[ST_IE];
  assign im = status_q[ST_IM_MSB:ST_IM_LSB];

  always_comb begin
    kind = EXC_NONE;
    if (bus.eret && !stk_empty)
      kind = EXC_ERET;
    else if (ie && bus.syscall && status_q[ST_SYS_EN])
      kind = EXC_SYSCALL;
    else if (ie && bus.breakc && status_q[ST_BRK_EN])
      kind = EXC_BREAK;
    else if (ie && bus.teq && bus.zero && status_q[ST_TEQ_EN])
      kind = EXC_TEQ;
    else if (ie && ((ip_q & im) != 8'h00))
      kind = EXC_INT;
  end

  // A full stack blocks every trap and interrupt; eret is still honoured.
  assign take_eret = (kind == EXC_ERET);
  assign take_exc  = (kind != EXC_NONE) && (kind != EXC_ERET) && !stk_full;
  assign redirect  = take_eret || take_exc;
  assign target    = take_eret ? epc_q : EXC_VECTOR;
  assign wr_en     = bus.mtc0 && !redirect;

  assign bus.redirect  = redirect;
  assign bus.cp0_addr  = redirect ? target : addr_q;
  assign bus.status    = status_q;
  assign bus.nest_full = stk_full;

  cp0_status_stack #(
    .DEPTH(NEST_DEPTH)
  ) u_stack (
    .clk        (clk),
    .rst        (rst),
    .push_i     (take_exc),
    .pop_i      (take_eret),
    .push_data_i(status_q),
    .top_o      (stk_top),
    .empty_o    (stk_empty),
    .full_o     (stk_full)
  );

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    status_d  = status_q;
    epc_d     = epc_q;
    exccode_d = exccode_q;
    addr_d    = redirect ? target : addr_q;

    if (TIMER_EN != 0) begin
      if (wr_en && bus.rd == CP0_COUNT) count_d = bus.wdata;
      else count_d = count_q + 32'd1;
    end else begin
      count_d = '0;
    end

    if (wr_en && bus.rd == CP0_COMPARE) compare_d = bus.wdata;

    if (take_exc) begin
      status_d = status_q & ~(32'h1 << ST_IE);
      epc_d = bus.pc;
      exccode_d = exc_code(kind);
    end else if (take_eret) begin
      status_d = stk_top & STATUS_WMASK;
    end else if (wr_en) begin
      case (bus.rd)
        CP0_STATUS: status_d  = bus.wdata & STATUS_WMASK;
        CP0_EPC:    epc_d     = bus.wdata;
        CP0_CAUSE:  exccode_d = bus.wdata[CA_EXC_MSB:CA_EXC_LSB];
        default:    ;
      endcase
    end
  end

  // IP[7] is sticky: the only way to drop it is a successful Compare write.
  always_comb begin
    ip_d = '0;
    for (int k = 0; k < NUM_IRQ; k++) ip_d[IP_HW_LSB + k] = bus.irq[k];
    if (TIMER_EN == 0)
      ip_d[IP_TIMER] = 1'b0;
    else if (wr_en && bus.rd == CP0_COMPARE)
      ip_d[IP_TIMER] = 1'b0;
    else if ((compare_q != '0) && (count_d == compare_q))
      ip_d[IP_TIMER] = 1'b1;
    else
      ip_d[IP_TIMER] = ip_q[IP_TIMER];
  end

  always_comb begin
    cause_w = '0;
    cause_w[CA_IP_MSB:CA_IP_LSB]   = ip_q;
    cause_w[CA_EXC_MSB:CA_EXC_LSB] = exccode_q;
  end

  always_comb begin
    rdata_w = '0;
    if (bus.mfc0) begin
      case (bus.rd)
        CP0_COUNT:   rdata_w = count_q;
        CP0_COMPARE: rdata_w = compare_q;
        CP0_STATUS:  rdata_w = status_q;
        CP0_CAUSE:   rdata_w = cause_w;
        CP0_EPC:     rdata_w = epc_q;
        default:     rdata_w = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= '0;
      epc_q     <= '0;
      addr_q    <= '0;
      exccode_q <= '0;
      ip_q      <= '0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      epc_q     <= epc_d;
      addr_q    <= addr_d;
      exccode_q <= exccode_d;
      ip_q      <= ip_d;
    end
  end

endmodule

// File: tb/tb_cp0_irq.sv
// Scoreboard bench for cp0_irq: expectations are queued with each driven cycle
// and compared mid-cycle against the DUT outputs.
module tb_cp0_irq;

  localparam int          NIRQ  = 5;
  localparam int          DEPTH = 2;
  localparam logic [31:0] VEC   = 32'h0040_0004;

  localparam int O_REDIR = 0;
  localparam int O_ADDR  = 1;
  localparam int O_RDATA = 2;
  localparam int O_STAT  = 3;
  localparam int O_FULL  = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  cp0_irq_if #(.NUM_IRQ(NIRQ)) bus ();

  cp0_irq #(
    .NUM_IRQ   (NIRQ),
    .NEST_DEPTH(DEPTH),
    .EXC_VECTOR(VEC),
    .TIMER_EN  (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      O_REDIR: return {31'b0, bus.redirect};
      O_ADDR:  return bus.cp0_addr;
      O_RDATA: return bus.rdata;
      O_STAT:  return bus.status;
      default: return {31'b0, bus.nest_full};
    endcase
  endfunction

  task automatic idle();
    bus.mfc0 = 1'b0; bus.mtc0 = 1'b0; bus.rd = 5'd0; bus.wdata = '0;
    bus.syscall = 1'b0; bus.breakc = 1'b0; bus.teq = 1'b0; bus.zero = 1'b0;
    bus.eret = 1'b0; bus.pc = '0;
  endtask

  task automatic expect_o(input int sel, input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  // Inputs are driven 1 time unit after the edge; outputs are sampled at the negedge.
  task automatic step();
    exp_t e;
    #4;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v, input string tag);
    bus.mtc0 = 1'b1; bus.rd = r; bus.wdata = v;
    expect_o(O_REDIR, tag, 32'd0);
    step();
  endtask

  task automatic rdc(input logic [4:0] r, input logic [31:0] v, input string tag);
    bus.mfc0 = 1'b1; bus.rd = r;
    expect_o(O_RDATA, tag, v);
    step();
  endtask

  task automatic trap_sys(input logic [31:0] pc, input logic taken, input string tag);
    bus.syscall = 1'b1; bus.pc = pc;
    expect_o(O_REDIR, tag, {31'b0, taken});
    if (taken) expect_o(O_ADDR, {tag, "_addr"}, VEC);
    step();
  endtask

  task automatic do_eret(input logic taken, input logic [31:0] addr, input string tag);
    bus.eret = 1'b1;
    expect_o(O_REDIR, tag, {31'b0, taken});
    expect_o(O_ADDR, {tag, "_addr"}, addr);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.irq = '0;
    idle();

    // reset state
    bus.mfc0 = 1'b1; bus.rd = 5'd12;
    expect_o(O_REDIR, "rst_redirect", 32'd0);
    expect_o(O_ADDR, "rst_addr", 32'd0);
    expect_o(O_RDATA, "rst_rdata", 32'd0);
    expect_o(O_STAT, "rst_status", 32'd0);
    expect_o(O_FULL, "rst_full", 32'd0);
    step();
    rst = 1'b0;

    // write masking, unimplemented index, rdata gating
    wr(5'd12, 32'hFFFF_FFFF, "wr_status_all");
    rdc(5'd12, 32'h0000_FF0F, "status_mask");
    wr(5'd12, 32'h0, "wr_status_clr");
    wr(5'd5, 32'h1234_5678, "wr_unimpl");
    rdc(5'd5, 32'h0, "rd_unimpl");
    bus.rd = 5'd12;
    expect_o(O_RDATA, "rdata_no_mfc0", 32'd0);
    step();

    // syscall trap and return
    wr(5'd12, 32'h3, "sys_wr_status");
    trap_sys(32'h0040_0100, 1'b1, "sys_redirect");
    rdc(5'd14, 32'h0040_0100, "sys_epc");
    rdc(5'd13, 32'h0000_0020, "sys_cause");
    rdc(5'd12, 32'h2, "sys_status");
    do_eret(1'b1, 32'h0040_0100, "sys_eret");
    expect_o(O_STAT, "sys_status_restored", 32'h3);
    step();
    do_eret(1'b0, 32'h0040_0100, "eret_empty_hold");
    wr(5'd12, 32'h0, "sys_clr");

    // syscall beats a pending interrupt; interrupt follows after eret
    wr(5'd12, 32'h402, "pri_wr_im");
    bus.irq = 5'b00001;
    wr(5'd12, 32'h403, "pri_wr_ie");
    trap_sys(32'h0040_0200, 1'b1, "pri_sys");
    expect_o(O_STAT, "pri_status", 32'h402);
    rdc(5'd13, 32'h0000_0420, "pri_cause");
    do_eret(1'b1, 32'h0040_0200, "pri_eret");
    bus.pc = 32'h0040_0300; bus.mtc0 = 1'b1; bus.rd = 5'd14; bus.wdata = 32'hDEAD_BEEF;
    expect_o(O_REDIR, "int_redirect", 32'd1);
    expect_o(O_ADDR, "int_addr", VEC);
    step();
    bus.irq = '0;
    rdc(5'd13, 32'h0000_0400, "int_cause");
    rdc(5'd14, 32'h0040_0300, "int_epc_no_mtc0");
    do_eret(1'b1, 32'h0040_0300, "int_eret");
    expect_o(O_REDIR, "int_no_retake", 32'd0);
    expect_o(O_STAT, "int_status", 32'h403);
    step();
    wr(5'd12, 32'h0, "pri_clr");

    // teq/break masking
    wr(5'd12, 32'h9, "teq_wr_status");
    bus.teq = 1'b1; bus.zero = 1'b0;
    expect_o(O_REDIR, "teq_zero0", 32'd0);
    step();
    bus.breakc = 1'b1;
    expect_o(O_REDIR, "brk_disabled", 32'd0);
    step();
    wr(5'd12, 32'h1, "teq_wr_noen");
    bus.teq = 1'b1; bus.zero = 1'b1;
    expect_o(O_REDIR, "teq_disabled", 32'd0);
    step();
    wr(5'd12, 32'h9, "teq_wr_en");
    bus.teq = 1'b1; bus.zero = 1'b1; bus.pc = 32'h0040_0400;
    expect_o(O_REDIR, "teq_taken", 32'd1);
    step();
    rdc(5'd13, 32'h0000_0034, "teq_cause");
    do_eret(1'b1, 32'h0040_0400, "teq_eret");
    wr(5'd12, 32'h0, "teq_clr");

    // nesting to full depth
    wr(5'd12, 32'h3, "nest_wr0");
    trap_sys(32'h0040_0500, 1'b1, "nest_sys1");
    rdc(5'd12, 32'h2, "nest_status1");
    wr(5'd12, 32'h7, "nest_wr1");
    trap_sys(32'h0040_0600, 1'b1, "nest_sys2");
    expect_o(O_FULL, "nest_full", 32'd1);
    expect_o(O_STAT, "nest_status2", 32'h6);
    wr(5'd12, 32'h3, "nest_wr2");
    trap_sys(32'h0040_0700, 1'b0, "nest_sys3_ignored");
    rdc(5'd14, 32'h0040_0600, "nest_epc");
    do_eret(1'b1, 32'h0040_0600, "nest_eret1");
    expect_o(O_STAT, "nest_pop1", 32'h7);
    expect_o(O_FULL, "nest_not_full", 32'd0);
    step();
    do_eret(1'b1, 32'h0040_0600, "nest_eret2");
    expect_o(O_STAT, "nest_pop2", 32'h3);
    step();
    do_eret(1'b0, 32'h0040_0600, "nest_eret_empty");
    wr(5'd12, 32'h0, "nest_clr");

    // Count/Compare timer
    wr(5'd12, 32'h8001, "tmr_wr_status");
    wr(5'd11, 32'd20, "tmr_wr_compare");
    wr(5'd9, 32'd0, "tmr_wr_count");
    rdc(5'd9, 32'd0, "tmr_count_pre");
    repeat (18) step();
    expect_o(O_REDIR, "tmr_not_yet", 32'd0);
    step();
    bus.pc = 32'h0040_0900;
    expect_o(O_REDIR, "tmr_int", 32'd1);
    expect_o(O_ADDR, "tmr_int_addr", VEC);
    step();
    rdc(5'd13, 32'h0000_8000, "tmr_cause");
    wr(5'd11, 32'd0, "tmr_clr_compare");
    rdc(5'd13, 32'h0000_0000, "tmr_ip_cleared");
    do_eret(1'b1, 32'h0040_0900, "tmr_eret");
    expect_o(O_REDIR, "tmr_no_retake", 32'd0);
    step();
    wr(5'd12, 32'h0, "tmr_clr");

    // reset in the middle of a nested handler
    wr(5'd12, 32'h3, "rh_wr0");
    trap_sys(32'h0040_0800, 1'b1, "rh_sys1");
    wr(5'd12, 32'h3, "rh_wr1");
    trap_sys(32'h0040_0804, 1'b1, "rh_sys2");
    expect_o(O_FULL, "rh_full", 32'd1);
    step();
    rst = 1'b1;
    bus.mfc0 = 1'b1; bus.rd = 5'd14;
    expect_o(O_RDATA, "rh_epc", 32'd0);
    expect_o(O_STAT, "rh_status", 32'd0);
    expect_o(O_FULL, "rh_full_clr", 32'd0);
    expect_o(O_REDIR, "rh_redirect", 32'd0);
    expect_o(O_ADDR, "rh_addr", 32'd0);
    step();
    rst = 1'b0;
    rdc(5'd13, 32'd0, "rh_cause");
    do_eret(1'b0, 32'd0, "rh_eret_empty");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
